// File: rtl/lcd_ram_arb.sv
// Two-requester character-RAM write arbiter gated by LCD vblank; LCD_RAM_ARB_RR_EN selects round-robin over fixed priority.
// Latency: req sampled in ARB -> ram_we/ack registered on the next cycle; at most one write per 2 cycles.
// Backpressure: requesters hold req/addr/data until ack; requests wait through active video and are never dropped.
`timescale 1ns/1ps
module lcd_ram_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        req0,
    input  logic        req1,
    input  logic [5:0]  addr0,
    input  logic [5:0]  addr1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        ram_we,
    output logic [5:0]  ram_wa,
    output logic [31:0] ram_wd,
    output logic [6:0]  wr_cnt
);

    typedef enum logic [1:0] {IDLE, ARB, WR} state_t;

    state_t state, state_nxt;
    logic   wr_start;
    logic   gnt_id;
    logic   vblank_d;
    logic   vblank_rise;

`ifdef LCD_RAM_ARB_RR_EN
    // last_gnt names the requester served most recently; the other one wins a tie
    logic last_gnt;

    always_comb begin
        if (req0 && req1) gnt_id = ~last_gnt;
        else              gnt_id = ~req0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        last_gnt <= 1'b1;
        else if (wr_start) last_gnt <= gnt_id;
    end
`else
    assign gnt_id = ~req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_start  = 1'b0;
        case (state)
            IDLE: if (vblank) state_nxt = ARB;
            ARB: begin
                if (!vblank) begin
                    state_nxt = IDLE;
                end else if (req0 || req1) begin
                    state_nxt = WR;
                    wr_start  = 1'b1;
                end
            end
            WR:      state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    // Write outputs are registered off wr_start so they are high exactly during WR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ram_wa <= '0;
            ram_wd <= '0;
        end else begin
            ram_we <= wr_start;
            ack0   <= wr_start & ~gnt_id;
            ack1   <= wr_start &  gnt_id;
            if (wr_start) begin
                ram_wa <= gnt_id ? addr1 : addr0;
                ram_wd <= gnt_id ? data1 : data0;
            end
        end
    end

    assign vblank_rise = vblank & ~vblank_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_d <= 1'b0;
            wr_cnt   <= '0;
        end else begin
            vblank_d <= vblank;
            if (vblank_rise)
                wr_cnt <= '0;
            else if (wr_start && wr_cnt != 7'd127)
                wr_cnt <= wr_cnt + 7'd1;
        end
    end

endmodule

// File: tb/tb_lcd_ram_arb.sv
// Scoreboard bench for lcd_ram_arb: directed scenarios push expected writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lcd_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblank = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [5:0]  addr0 = '0, addr1 = '0;
    logic [31:0] data0 = '0, data1 = '0;
    logic        ack0, ack1, ram_we;
    logic [5:0]  ram_wa;
    logic [31:0] ram_wd;
    logic [6:0]  wr_cnt;

    lcd_ram_arb dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [5:0]  addr;
        logic [31:0] data;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit id, input logic [5:0] a, input logic [31:0] d, input int cnt, input int c);
        exp_t e;
        e.id = id; e.addr = a; e.data = d; e.cnt = cnt; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit id);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = id ? ack1 : ack0;
        end
        check(id ? "wait_ack1" : "wait_ack0", {63'd0, seen}, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every write cycle must match the oldest expectation
    always @(negedge clk) begin
        if (ram_we || ack0 || ack1) begin
            check("ack_exclusive", {63'd0, ack0 & ack1}, 64'd0);
            check("ack_matches_we", {63'd0, ack0 | ack1}, {63'd0, ram_we});
            if (sb.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("grant_id", {63'd0, ack1}, {63'd0, e.id});
                check("ram_wa", {58'd0, ram_wa}, {58'd0, e.addr});
                check("ram_wd", {32'd0, ram_wd}, {32'd0, e.data});
                check("wr_cnt", {57'd0, wr_cnt}, 64'(e.cnt));
                check("write_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        step();
        step();
        check("rst_ram_we", {63'd0, ram_we}, 64'd0);
        check("rst_ack0", {63'd0, ack0}, 64'd0);
        check("rst_ack1", {63'd0, ack1}, 64'd0);
        check("rst_ram_wa", {58'd0, ram_wa}, 64'd0);
        check("rst_ram_wd", {32'd0, ram_wd}, 64'd0);
        check("rst_wr_cnt", {57'd0, wr_cnt}, 64'd0);

        // Single write from requester 0
        vblank = 1'b1;
        rst_n = 1'b1;
        step();
        req0 = 1'b1; addr0 = 6'd5; data0 = 32'hA5A5_0F0F;
        push(0, 6'd5, 32'hA5A5_0F0F, 1, cyc + 1);
        wait_ack(0);
        step();
        req0 = 1'b0;

        // Both requesters held for 8 cycles from a fresh reset
        do_reset();
        n = cyc;
        req0 = 1'b1; addr0 = 6'd10; data0 = 32'h1111_0000;
        req1 = 1'b1; addr1 = 6'd20; data1 = 32'h2222_FFFF;
        for (int i = 0; i < 4; i++) begin
`ifdef LCD_RAM_ARB_RR_EN
            if (i % 2 == 0) push(0, 6'd10, 32'h1111_0000, i + 1, n + 1 + 2 * i);
            else            push(1, 6'd20, 32'h2222_FFFF, i + 1, n + 1 + 2 * i);
`else
            push(0, 6'd10, 32'h1111_0000, i + 1, n + 1 + 2 * i);
`endif
        end
        repeat (8) step();
        req0 = 1'b0; req1 = 1'b0;

        // Request during active video waits for the next window
        vblank = 1'b0;
        req1 = 1'b1; addr1 = 6'd33; data1 = 32'hDEAD_BEEF;
        repeat (100) step();
        vblank = 1'b1;
        push(1, 6'd33, 32'hDEAD_BEEF, 1, cyc + 2);
        wait_ack(1);
        step();
        req1 = 1'b0;

        // vblank falls during WR; follow-up request held over active video
        req0 = 1'b1; addr0 = 6'd7; data0 = 32'h0000_0007;
        push(0, 6'd7, 32'h0000_0007, 2, cyc + 1);
        wait_ack(0);
        vblank = 1'b0;
        step();
        addr0 = 6'd8; data0 = 32'h8888_8888;
        repeat (10) step();
        vblank = 1'b1;
        push(0, 6'd8, 32'h8888_8888, 1, cyc + 2);
        wait_ack(0);
        step();
        req0 = 1'b0;

        // 130 back-to-back writes: counter saturates at 127
        n = cyc;
        req0 = 1'b1; addr0 = 6'd63; data0 = 32'hFFFF_FFFF;
        for (int i = 0; i < 130; i++)
            push(0, 6'd63, 32'hFFFF_FFFF, (2 + i > 127) ? 127 : 2 + i, n + 1 + 2 * i);
        repeat (260) step();
        req0 = 1'b0;
        check("cnt_saturated", {57'd0, wr_cnt}, 64'd127);
        vblank = 1'b0;
        step();
        step();
        vblank = 1'b1;
        check("cnt_before_rise", {57'd0, wr_cnt}, 64'd127);
        step();
        check("cnt_cleared", {57'd0, wr_cnt}, 64'd0);

        // Reset asserted in the middle of a WR cycle
        req1 = 1'b1; addr1 = 6'd44; data1 = 32'h4444_1234;
        push(1, 6'd44, 32'h4444_1234, 1, cyc + 1);
        step();
        check("pre_reset_we", {63'd0, ram_we}, 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midwr_ram_we", {63'd0, ram_we}, 64'd0);
        check("midwr_ack1", {63'd0, ack1}, 64'd0);
        check("midwr_ram_wa", {58'd0, ram_wa}, 64'd0);
        check("midwr_wr_cnt", {57'd0, wr_cnt}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        push(1, 6'd44, 32'h4444_1234, 1, cyc + 2);
        wait_ack(1);
        step();
        req1 = 1'b0;

        repeat (5) step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_ram_arb.md
LCD_RAM_ARB -- requirements
Module: lcd_ram_arb

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 25 MHz, same domain as LCD timing.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: vblank  input  1  high when the LCD scan is not reading the character RAM; synchronous to clk.
REQ-004 SHALL have ports: req0/req1  input  1  write request from requester 0/1.
REQ-005 SHALL have ports: addr0/addr1  input  6  target RAM row, 0-63.
REQ-006 SHALL have ports: data0/data1  input  32  row bitmap, one bit per pixel.
REQ-007 SHALL have ports: ack0/ack1  output  1  one-cycle write-done pulse per requester.
REQ-008 SHALL have port: ram_we  output  1  character RAM write enable, one cycle per write.
REQ-009 SHALL have port: ram_wa  output  6  character RAM write address.
REQ-010 SHALL have port: ram_wd  output  32  character RAM write data.
REQ-011 SHALL have port: wr_cnt  output  7  number of writes in the current blanking window.
REQ-012 SHALL register all outputs; no combinational path from any input to any output.

Function
REQ-013 SHALL implement the states IDLE, ARB and WR.
REQ-014 IDLE: SHALL go to ARB when vblank=1; otherwise SHALL stay in IDLE.
REQ-015 ARB: if vblank=0, SHALL go to IDLE with no grant.
REQ-016 ARB: otherwise, if any req is high, SHALL latch the winner's addr/data and go to WR; with no req, SHALL stay in ARB.
REQ-017 WR: SHALL drive ram_we=1, ram_wa/ram_wd with the latched values, and pulse the winner's ack for exactly this cycle, then go to ARB.
REQ-018 Latency: req sampled high in ARB -> ram_we and ack on the next cycle.
REQ-019 Throughput: at most one write per 2 cycles; back-to-back writes with req held high SHALL alternate ARB and WR.
REQ-020 Requester SHALL hold req/addr/data stable until ack; the cycle after ack it MAY drop req or present a new address/data.
REQ-021 ack0 and ack1 SHALL never be high in the same cycle.
REQ-022 Outside WR, ram_we SHALL be 0; ram_wa/ram_wd SHALL hold their last values.
REQ-023 vblank falling during WR: the write SHALL complete, and the next state SHALL be ARB, then IDLE.
REQ-024 No write SHALL start while vblank=0.
REQ-025 wr_cnt SHALL clear to 0 on the cycle after a vblank rising edge.
REQ-026 wr_cnt SHALL increment on each WR cycle and saturate at 127.
REQ-027 If the vblank rising edge and WR occur in the same cycle, clear SHALL win.
REQ-028 Pending requests SHALL persist across active video and be served in the next window; none SHALL be dropped.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE; ack0=ack1=0; ram_we=0; ram_wa=0; ram_wd=0; wr_cnt=0; round-robin pointer=1 (last grant = requester 1).
REQ-030 Reset mid-WR SHALL abort the write and ack; the requester SHALL still see req pending after reset release.

Configuration
REQ-031 Macro LCD_RAM_ARB_RR_EN defined: on simultaneous req0 and req1, the requester not granted last SHALL win; the pointer SHALL update on each WR.
REQ-032 Macro LCD_RAM_ARB_RR_EN undefined: fixed priority, with req0 always winning; the pointer logic SHALL be absent.

Verification
REQ-033 Reset, vblank=1, req0 with addr0=6'd5, data0=32'hA5A5_0F0F -> next cycle ram_we=1, ram_wa=5, ram_wd=32'hA5A5_0F0F, ack0=1, wr_cnt=1.
REQ-034 req0 and req1 held high for 8 cycles in vblank, RR_EN defined -> grants 0,1,0,1 on alternate cycles; RR_EN undefined -> four grants to requester 0.
REQ-035 req1 asserted while vblank=0 for 100 cycles -> no ram_we and no ack1; the write occurs 2 cycles after vblank rises.
REQ-036 vblank falls in the WR cycle -> that write completes, and no further ram_we occurs until vblank is next high.
REQ-037 130 continuous writes in one window -> wr_cnt saturates at 127, then returns to 0 after the next vblank rising edge.
REQ-038 rst_n pulsed low during WR -> ram_we and ack drop immediately, state=IDLE, and the request is served again after release.
